// File: rtl/prefix_add_arbiter_if.sv
// Request/response bundle for the shared prefix-adder arbiter.
// N_REQ operand ports in, one tagged sum port out.
interface prefix_add_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [16*N_REQ-1:0] req_a;
   logic [16*N_REQ-1:0] req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [15:0]         rsp_sum;
   logic                rsp_cout;
   logic [ID_W-1:0]     rsp_id;
   logic                busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
   );
endinterface

// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter sharing one 16-bit prefix adder between N_REQ
// requesters through an operand stage and a response stage.
module GPTPrefix16_L5 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum,
   output logic        cout
);
   // Han-Carlson: odd bits run Kogge-Stone, even bits fixed up last
   localparam logic [15:0] M1 = 16'hAAAA;
   localparam logic [15:0] M2 = 16'hAAA8;
   localparam logic [15:0] M3 = 16'hAAA0;
   localparam logic [15:0] M4 = 16'hAA00;
   localparam logic [15:0] M5 = 16'h5554;

   logic [15:0] g0, p0, g1, p1, g2, p2;
   logic [15:0] g3, p3, g4, p4, g5;

   assign g0 = a & b;
   assign p0 = a ^ b;

   assign g1 = g0 | (M1 & p0 & (g0 << 1));
   assign p1 = p0 & ((p0 << 1) | ~M1);

   assign g2 = g1 | (M2 & p1 & (g1 << 2));
   assign p2 = p1 & ((p1 << 2) | ~M2);

   assign g3 = g2 | (M3 & p2 & (g2 << 4));
   assign p3 = p2 & ((p2 << 4) | ~M3);

   assign g4 = g3 | (M4 & p3 & (g3 << 8));
   assign p4 = p3 & ((p3 << 8) | ~M4);

   assign g5 = g4 | (M5 & p4 & (g4 << 1));

   assign sum  = p0 ^ {g5[14:0], 1'b0};
   assign cout = g5[15];
endmodule

module prefix_add_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
   input logic                 clk,
   input logic                 rst,
   prefix_add_arbiter_if.slave bus
);
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  ptr_nxt;
   logic [ID_W-1:0]  gnt_id;
   logic [N_REQ-1:0] gnt;
   logic             found;
   logic [15:0]      sel_a;
   logic [15:0]      sel_b;

   logic             o_valid;
   logic [15:0]      o_a;
   logic [15:0]      o_b;
   logic [ID_W-1:0]  o_id;

   logic             rsp_valid;
   logic [15:0]      rsp_sum;
   logic             rsp_cout;
   logic [ID_W-1:0]  rsp_id;

   logic [15:0]      add_sum;
   logic             add_cout;
   logic             r_load;
   logic             o_load;
   logic             take;

   assign r_load = !rsp_valid || bus.rsp_ready;
   assign o_load = !o_valid || r_load;
   assign take   = o_load && found;

   // First valid requester at or after ptr, wrapping
   always_comb begin
      int idx;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      sel_a  = '0;
      sel_b  = '0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && bus.req_valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = ID_W'(idx);
            sel_a    = bus.req_a[16*idx +: 16];
            sel_b    = bus.req_b[16*idx +: 16];
         end
      end
   end

   assign ptr_nxt = (gnt_id == ID_W'(N_REQ - 1)) ? '0
                                                 : gnt_id + 1'b1;

   assign bus.req_ready = (o_load && !rst) ? gnt : '0;

   GPTPrefix16_L5 u_add (
      .a    (o_a),
      .b    (o_b),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         o_valid   <= 1'b0;
         o_a       <= '0;
         o_b       <= '0;
         o_id      <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= '0;
      end else begin
         if (r_load) begin
            rsp_valid <= o_valid;
            if (o_valid) begin
               rsp_sum  <= add_sum;
               rsp_cout <= add_cout;
               rsp_id   <= o_id;
            end
         end
         if (o_load) begin
            o_valid <= found;
            if (found) begin
               o_a  <= sel_a;
               o_b  <= sel_b;
               o_id <= gnt_id;
            end
         end
         if (take) begin
            ptr <= ptr_nxt;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_sum   = rsp_sum;
   assign bus.rsp_cout  = rsp_cout;
   assign bus.rsp_id    = rsp_id;
   assign bus.busy      = o_valid | rsp_valid;
endmodule
